// File: rtl/layer_input_sequencer.sv
// Loads NUM_INPUTS values into neuron input registers over a PIO-style write bus,
// pulses layer_start, then waits for layer_done with a bounded timeout.
module layer_input_sequencer #(
  parameter int NUM_INPUTS = 4,
  parameter int IDX_W      = 2,
  parameter int DATA_W     = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [1:0]            pio_address,
  output logic [NUM_INPUTS-1:0] pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  output logic                  layer_start,
  input  logic                  layer_done,
  output logic                  busy,
  output logic [IDX_W-1:0]      input_index,
  output logic                  timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    START,
    WAIT
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   hold_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                terr_q;

  // NOTE: every register here is state, so it is assigned with <= only; a blocking
  // assignment would let later statements see the new value within the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hold_q  <= in_data;
            idx_q   <= '0;
            state_q <= WRITE;
          end
        end
        LOAD: begin
          if (in_valid) begin
            hold_q  <= in_data;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (idx_q == LAST_IDX) begin
            terr_q  <= 1'b0;
            state_q <= START;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= LOAD;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a timeout that expires in the same cycle.
          if (layer_done) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == LAST_CNT) begin
            idx_q   <= '0;
            terr_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          idx_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready       = (state_q == IDLE) || (state_q == LOAD);
  assign busy           = (state_q != IDLE);
  assign layer_start    = (state_q == START);
  assign pio_address    = 2'b00;
  assign pio_write_n    = (state_q != WRITE);
  assign pio_chipselect = (state_q == WRITE) ? (NUM_INPUTS'(1) << idx_q) : '0;
  assign pio_writedata  = (state_q == WRITE) ? 32'(hold_q) : 32'd0;
  assign input_index    = idx_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_layer_input_sequencer.sv
// Directed bench for layer_input_sequencer: full and bursty passes, done, timeout,
// done/timeout collision, ignored layer_done, and reset in mid-pass.
module tb_layer_input_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_ready;
  logic [1:0]  pio_address;
  logic [3:0]  pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        layer_start;
  logic        layer_done;
  logic        busy;
  logic [1:0]  input_index;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  layer_input_sequencer #(
    .NUM_INPUTS(4),
    .IDX_W     (2),
    .DATA_W    (9),
    .TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .pio_address   (pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n   (pio_write_n),
    .pio_writedata (pio_writedata),
    .layer_start   (layer_start),
    .layer_done    (layer_done),
    .busy          (busy),
    .input_index   (input_index),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    32'(pio_chipselect), 32'h0);
    check({tag, "_wn"},    32'(pio_write_n),    32'h1);
    check({tag, "_wd"},    pio_writedata,       32'h0);
    check({tag, "_rdy"},   32'(in_ready),       32'h1);
    check({tag, "_busy"},  32'(busy),           32'h0);
    check({tag, "_start"}, 32'(layer_start),    32'h0);
    check({tag, "_idx"},   32'(input_index),    32'h0);
    check({tag, "_terr"},  32'(timeout_err),    32'h0);
    check({tag, "_addr"},  32'(pio_address),    32'h0);
  endtask

  // Loads four values from IDLE and stops in the first WAIT cycle. gap = LOAD cycles
  // with in_valid low between values; pulse_done raises layer_done inside a LOAD cycle.
  task automatic run_load(input logic [3:0][8:0] v, input int gap, input bit pulse_done,
                          input logic exp_terr);
    logic [3:0] exp_cs;
    for (int i = 0; i < 4; i++) begin
      in_data  = v[i];
      in_valid = 1'b1;
      step();
      exp_cs = 4'b0001 << i;
      check("wr_cs",   32'(pio_chipselect), 32'(exp_cs));
      check("wr_wd",   pio_writedata,       32'(v[i]));
      check("wr_wn",   32'(pio_write_n),    32'h0);
      check("wr_rdy",  32'(in_ready),       32'h0);
      check("wr_idx",  32'(input_index),    32'(i));
      if (i == 0) check("wr_terr", 32'(timeout_err), 32'(exp_terr));
      if (i < 3) begin
        in_data  = v[i+1];
        in_valid = (gap == 0);
        step();
        check("ld_wn",   32'(pio_write_n),    32'h1);
        check("ld_cs",   32'(pio_chipselect), 32'h0);
        check("ld_rdy",  32'(in_ready),       32'h1);
        check("ld_idx",  32'(input_index),    32'(i + 1));
        for (int g = 1; g < gap; g++) begin
          if (pulse_done && g == 1) layer_done = 1'b1;
          step();
          layer_done = 1'b0;
          check("gap_wn",   32'(pio_write_n), 32'h1);
          check("gap_rdy",  32'(in_ready),    32'h1);
          check("gap_busy", 32'(busy),        32'h1);
          check("gap_idx",  32'(input_index), 32'(i + 1));
        end
        in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    step();
    check("st_start", 32'(layer_start),    32'h1);
    check("st_wn",    32'(pio_write_n),    32'h1);
    check("st_cs",    32'(pio_chipselect), 32'h0);
    check("st_rdy",   32'(in_ready),       32'h0);
    check("st_terr",  32'(timeout_err),    32'h0);
    step();
    check("wt_start", 32'(layer_start),    32'h0);
    check("wt_busy",  32'(busy),           32'h1);
    check("wt_rdy",   32'(in_ready),       32'h0);
  endtask

  initial begin
    // NOTE: the bench drives inputs with blocking assignments so each step's stimulus
    // is settled before the next rising edge samples it.
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    layer_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    step();
    step();
    reset = 1'b0;
    step();
    check_reset_outputs("idle");

    // Full pass, in_valid held high; done on the 5th WAIT cycle.
    run_load({9'h155, 9'h0AA, 9'h001, 9'h1FF}, 0, 1'b0, 1'b0);
    repeat (4) step();
    check("done_pre_busy", 32'(busy), 32'h1);
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    check("done_busy", 32'(busy),        32'h0);
    check("done_terr", 32'(timeout_err), 32'h0);
    check("done_idx",  32'(input_index), 32'h0);
    check("done_rdy",  32'(in_ready),    32'h1);

    // Bursty source with layer_done pulsed during LOAD; then timeout.
    run_load({9'h155, 9'h0AA, 9'h001, 9'h1FF}, 3, 1'b1, 1'b0);
    repeat (7) step();
    check("to_pre_busy", 32'(busy),        32'h1);
    check("to_pre_terr", 32'(timeout_err), 32'h0);
    step();
    check("to_busy", 32'(busy),        32'h0);
    check("to_terr", 32'(timeout_err), 32'h1);
    check("to_idx",  32'(input_index), 32'h0);
    step();
    check("to_sticky", 32'(timeout_err), 32'h1);

    // Next pass clears the flag at START; done arrives in the timeout cycle.
    run_load({9'h055, 9'h100, 9'h00F, 9'h0F0}, 0, 1'b0, 1'b1);
    repeat (7) step();
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    check("sim_busy", 32'(busy),        32'h0);
    check("sim_terr", 32'(timeout_err), 32'h0);

    // Reset asserted during the WRITE of index 2.
    in_valid = 1'b1;
    in_data  = 9'h011;
    step();
    in_data = 9'h022;
    step();
    step();
    in_data = 9'h033;
    step();
    step();
    check("pre_rst_cs",  32'(pio_chipselect), 32'h4);
    check("pre_rst_idx", 32'(input_index),    32'h2);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    in_valid = 1'b0;
    step();
    step();
    check_reset_outputs("hold_rst");
    reset = 1'b0;
    run_load({9'h0C3, 9'h03C, 9'h1A5, 9'h05A}, 0, 1'b0, 1'b0);
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_input_sequencer.md
LAYER_INPUT_SEQUENCER -- requirements
Module: layer_input_sequencer

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4, number of neuron input registers loaded per layer pass (legal 2..16).
REQ-002 SHALL have parameter IDX_W, default 2, index width; 2**IDX_W >= NUM_INPUTS.
REQ-003 SHALL have parameter DATA_W, default 9, input value width; legal 1..32.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting for layer_done; legal >= 2.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, input value available.
REQ-008 SHALL have port in_data, input, DATA_W, input value.
REQ-009 SHALL have port in_ready, output, 1, sequencer accepts in_data.
REQ-010 SHALL have port pio_address, output, 2, register address to the input registers; constant 0.
REQ-011 SHALL have port pio_chipselect, output, NUM_INPUTS, one-hot select; bit k selects input register k.
REQ-012 SHALL have port pio_write_n, output, 1, active-low write strobe.
REQ-013 SHALL have port pio_writedata, output, 32, write data, zero-extended from DATA_W.
REQ-014 SHALL have port layer_start, output, 1, one-cycle pulse that starts the layer computation.
REQ-015 SHALL have port layer_done, input, 1, layer computation complete.
REQ-016 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-017 SHALL have port input_index, output, IDX_W, index of the register currently being loaded.
REQ-018 SHALL have port timeout_err, output, 1, sticky flag: the last pass timed out.

Function
REQ-019 SHALL implement states IDLE, LOAD, WRITE, START and WAIT, with all outputs decoded from registered state.
REQ-020 SHALL drive in_ready=1 only in IDLE and LOAD.
REQ-021 On in_valid&in_ready in IDLE, SHALL capture in_data into the hold register, set index=0, and go to WRITE; in LOAD the same handshake SHALL capture the data, keep the index, and go to WRITE.
REQ-022 In WRITE, for exactly one cycle, SHALL drive pio_chipselect[index]=1, pio_write_n=0 and pio_writedata={zeros, hold}; in all other states SHALL drive pio_chipselect=0, pio_write_n=1 and pio_writedata=0.
REQ-023 After WRITE, if index==NUM_INPUTS-1, SHALL go to START; otherwise SHALL increment index and go to LOAD. The index SHALL never exceed NUM_INPUTS-1 and SHALL wrap to 0 only on entering IDLE.
REQ-024 Latency: a handshake at edge N SHALL produce the write strobe in the cycle after edge N; the last write cycle SHALL be followed directly by a one-cycle layer_start pulse in START, then WAIT.
REQ-025 On entering START, SHALL clear timeout_err.
REQ-026 In WAIT, SHALL count cycles from 0. layer_done=1 SHALL send the FSM to IDLE. If the count reaches TIMEOUT-1 with layer_done=0, SHALL go to IDLE and set timeout_err=1.
REQ-027 layer_done SHALL be ignored outside WAIT; if layer_done=1 in the timeout cycle, done SHALL win and timeout_err SHALL stay 0.
REQ-028 in_valid while in WRITE, START or WAIT SHALL stall the source; no data SHALL be dropped or duplicated.
REQ-029 input_index SHALL equal the internal index register in every state.

Reset
REQ-030 While reset=1, asynchronously: state=IDLE, index=0, hold=0, count=0, timeout_err=0, in_ready=1, busy=0, layer_start=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
REQ-031 Reset asserted mid-pass SHALL abort the pass immediately, with no further write strobes or layer_start pulses.

Verification
REQ-032 Full pass: 4 values 0x1FF, 0x001, 0x0AA, 0x155 with in_valid held high -> chipselect 0001, 0010, 0100, 1000 on alternate cycles, writedata 0x000001FF..0x00000155, then one layer_start pulse.
REQ-033 Bursty source: in_valid low for 3 cycles between values -> same write sequence, in_ready low during every WRITE cycle, no extra strobes.
REQ-034 Done: layer_done=1 on the 5th WAIT cycle -> IDLE the next cycle, busy=0, timeout_err=0.
REQ-035 Timeout: TIMEOUT=8, layer_done held 0 -> IDLE after 8 WAIT cycles, timeout_err=1; the next pass's START clears it.
REQ-036 Simultaneous: layer_done=1 exactly in the 8th WAIT cycle (TIMEOUT=8) -> IDLE with timeout_err=0; layer_done pulsed during LOAD -> ignored.
REQ-037 Reset during WRITE of index 2 -> all outputs at reset values at once, input_index=0, and the next pass restarts at chipselect 0001.
